axil_cmd_master: RTL and testbench
==================================

// Module: axil_cmd_master
// PURPOSE
// - AXI4-Lite initiator: the requesting end of the register-bus protocol served by the axi_register slave.
// - Takes read/write commands through a push/full interface and returns responses through a pop/empty interface.
// - Both interfaces use the same push/pop semantics as the team FIFO, so the command and response sides connect directly to FIFOs.
// - Exactly one AXI transaction is outstanding at a time.
// PARAMETERS
// - AddrWidth  32  byte address width for awaddr/araddr/cmd_addr
// - DataWidth  32  data width; must be 32 or 64; strobe width = DataWidth/8
// PORTS
// - clk         in   1             clock, all logic on rising edge
// - reset_n     in   1             asynchronous reset, active-low
// - cmd_push    in   1             command offered; accepted when ~cmd_full
// - cmd_full    out  1             command slot busy
// - cmd_write   in   1             1 = write, 0 = read
// - cmd_addr    in   AddrWidth     target address
// - cmd_wdata   in   DataWidth     write data (ignored for reads)
// - cmd_wstrb   in   DataWidth/8   write strobes (ignored for reads)
// - rsp_pop     in   1             consume response; ignored when rsp_empty
// - rsp_empty   out  1             no response held
// - rsp_write   out  1             held response belongs to a write
// - rsp_data    out  DataWidth     read data; 0 for writes
// - rsp_resp    out  2             BRESP/RRESP of the held response
// - m_awvalid/m_awready out/in 1, m_awaddr out AddrWidth, m_awprot out 3   AW channel
// - m_wvalid/m_wready   out/in 1, m_wdata out DataWidth, m_wstrb out DataWidth/8   W channel
// - m_bvalid/m_bready   in/out 1, m_bresp in 2   B channel
// - m_arvalid/m_arready out/in 1, m_araddr out AddrWidth, m_arprot out 3   AR channel
// - m_rvalid/m_rready   in/out 1, m_rdata in DataWidth, m_rresp in 2   R channel
// BEHAVIOUR
// - Reset (async, reset_n=0): state IDLE; all m_*valid and m_*ready = 0; cmd_full = 0; rsp_empty = 1.
//   Reset values of remaining outputs: rsp_write = 0, rsp_data = 0, rsp_resp = 0, address/data/strobe outputs = 0.
//   A mid-transaction reset abandons the transaction with no response produced.
// - m_awprot and m_arprot are constant 3'b000.
// - FSM states: IDLE, WRITE, BRESP, READ, RDATA.
// - cmd_full = (state != IDLE). A push while cmd_full is high is ignored.
// - IDLE: on cmd_push, register addr/wdata/wstrb and go to WRITE (cmd_write=1) or READ (cmd_write=0).
//   m_*valid rises the cycle after the push, driven from registers.
// - WRITE:
//   - m_awvalid and m_wvalid are asserted together.
//   - Each drops independently on its own handshake, tracked by aw_done/w_done flags.
//   - Leave for BRESP once both flags are done; this includes the case where both handshakes occur in the same cycle.
//   - AW-before-W, W-before-AW and simultaneous handshakes are all legal.
// - BRESP: m_bready = rsp_empty.
//   - On m_bvalid & m_bready: rsp_write=1, rsp_resp=m_bresp, rsp_data=0, rsp_empty=0, state IDLE.
// - READ: m_arvalid held until m_arready, then go to RDATA.
// - RDATA: m_rready = rsp_empty.
//   - On handshake: rsp_write=0, rsp_data=m_rdata, rsp_resp=m_rresp, rsp_empty=0, state IDLE.
// - Valid stability: once any m_*valid is asserted, it and its payload stay stable until the handshake. No combinational path from any AXI input to any m_*valid.
// - Response register: loaded only while empty, so a load and a pop never coincide.
//   - rsp_pop & ~rsp_empty sets rsp_empty=1 next cycle; the data fields hold their values.
// - Backpressure: a full response register stalls BRESP/RDATA by holding m_bready/m_rready low.
//   A new command is accepted in IDLE even while a response is held.
// - Latency with a zero-wait slave: push at cycle 0, AW/W at cycle 1, B at cycle 2, rsp_empty=0 at cycle 3, next push accepted at cycle 3.
// - Non-zero m_bresp/m_rresp (SLVERR/DECERR) are passed through unchanged; no retry.
// TESTING
// - Write, zero-wait slave: push wr addr=0x10 data=0xDEADBEEF strb=0xF.
//   -> AW/W at cycle 1; rsp_write=1, rsp_resp=0 at cycle 3; cmd_full low at cycle 3.
// - Read, 3-cycle arready + 2-cycle rvalid delay, rdata=0x12345678.
//   -> m_arvalid and m_araddr stable until handshake; rsp_data=0x12345678, rsp_resp=0.
// - Split write: wready 4 cycles before awready, then the reverse order.
//   -> m_wvalid drops after the W handshake, m_awvalid stays high until its handshake; one response per command.
// - Backpressure: leave a response unpopped, then issue a read.
//   -> m_rready=0 while rsp_empty=0; rsp_pop releases rready; second push while cmd_full is ignored; no response is lost.
// - Error plus reset: slave returns bresp=2'b10 -> rsp_resp=2'b10.
//   Then assert reset_n=0 during READ with m_arvalid=1 -> m_arvalid=0 immediately, cmd_full=0, rsp_empty=1.

Source files
------------

// File: rtl/axil_cmd_master.sv
// -----------------------------------------------------------------------------
// axil_cmd_master
// -----------------------------------------------------------------------------
// AXI4-Lite initiator with one transaction in flight at a time. Commands come in
// through a push/full interface and responses leave through a pop/empty
// interface, so both sides can connect directly to FIFOs.
//
// Ports
//   clk, reset_n                   clock (rising edge) and async active-low reset
//   cmd_push / cmd_full            command handshake; push accepted when ~cmd_full
//   cmd_write, cmd_addr,
//   cmd_wdata, cmd_wstrb           command payload (wdata/wstrb unused for reads)
//   rsp_pop / rsp_empty            response handshake; pop ignored when empty
//   rsp_write, rsp_data, rsp_resp  held response (rsp_data is 0 for writes)
//   m_aw*, m_w*, m_b*, m_ar*, m_r* AXI4-Lite master channels
//
// DataWidth is expected to be 32 or 64; strobe width is DataWidth/8.
// -----------------------------------------------------------------------------
module axil_cmd_master #(
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    // command side
    input  logic                   cmd_push,
    output logic                   cmd_full,
    input  logic                   cmd_write,
    input  logic [AddrWidth-1:0]   cmd_addr,
    input  logic [DataWidth-1:0]   cmd_wdata,
    input  logic [DataWidth/8-1:0] cmd_wstrb,
    // response side
    input  logic                   rsp_pop,
    output logic                   rsp_empty,
    output logic                   rsp_write,
    output logic [DataWidth-1:0]   rsp_data,
    output logic [1:0]             rsp_resp,
    // AW channel
    output logic                   m_awvalid,
    input  logic                   m_awready,
    output logic [AddrWidth-1:0]   m_awaddr,
    output logic [2:0]             m_awprot,
    // W channel
    output logic                   m_wvalid,
    input  logic                   m_wready,
    output logic [DataWidth-1:0]   m_wdata,
    output logic [DataWidth/8-1:0] m_wstrb,
    // B channel
    input  logic                   m_bvalid,
    output logic                   m_bready,
    input  logic [1:0]             m_bresp,
    // AR channel
    output logic                   m_arvalid,
    input  logic                   m_arready,
    output logic [AddrWidth-1:0]   m_araddr,
    output logic [2:0]             m_arprot,
    // R channel
    input  logic                   m_rvalid,
    output logic                   m_rready,
    input  logic [DataWidth-1:0]   m_rdata,
    input  logic [1:0]             m_rresp
);

    localparam int StrbWidth = DataWidth / 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_BRESP = 3'd2,
        ST_READ  = 3'd3,
        ST_RDATA = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;

    logic [AddrWidth-1:0]   r_addr;
    logic [DataWidth-1:0]   r_wdata;
    logic [StrbWidth-1:0]   r_wstrb;
    logic                   r_aw_done;
    logic                   r_w_done;

    logic                   r_rsp_empty;
    logic                   r_rsp_write;
    logic [DataWidth-1:0]   r_rsp_data;
    logic [1:0]             r_rsp_resp;

    logic                   w_cmd_accept;
    logic                   w_aw_hs;
    logic                   w_w_hs;
    logic                   w_b_hs;
    logic                   w_ar_hs;
    logic                   w_r_hs;

    // Channel payloads come straight from the command registers, so they are
    // stable for as long as the corresponding valid is high.
    assign m_awaddr  = r_addr;
    assign m_araddr  = r_addr;
    assign m_wdata   = r_wdata;
    assign m_wstrb   = r_wstrb;
    assign m_awprot  = 3'b000;
    assign m_arprot  = 3'b000;

    assign rsp_empty = r_rsp_empty;
    assign rsp_write = r_rsp_write;
    assign rsp_data  = r_rsp_data;
    assign rsp_resp  = r_rsp_resp;

    assign w_cmd_accept = (r_state == ST_IDLE) & cmd_push;
    assign w_aw_hs      = m_awvalid & m_awready;
    assign w_w_hs       = m_wvalid  & m_wready;
    assign w_b_hs       = m_bvalid  & m_bready;
    assign w_ar_hs      = m_arvalid & m_arready;
    assign w_r_hs       = m_rvalid  & m_rready;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (cmd_push) begin
                    w_state_next = cmd_write ? ST_WRITE : ST_READ;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_WRITE: begin
                // A handshake in this cycle counts the same as an already-set
                // flag, so simultaneous AW/W completion leaves in one step.
                if ((r_aw_done | w_aw_hs) & (r_w_done | w_w_hs)) begin
                    w_state_next = ST_BRESP;
                end else begin
                    w_state_next = ST_WRITE;
                end
            end
            ST_BRESP: begin
                if (w_b_hs) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_BRESP;
                end
            end
            ST_READ: begin
                if (w_ar_hs) begin
                    w_state_next = ST_RDATA;
                end else begin
                    w_state_next = ST_READ;
                end
            end
            ST_RDATA: begin
                if (w_r_hs) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_RDATA;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Output decode; only registered state feeds valid/ready, never an AXI input.
    always_comb begin
        cmd_full  = 1'b1;
        m_awvalid = 1'b0;
        m_wvalid  = 1'b0;
        m_bready  = 1'b0;
        m_arvalid = 1'b0;
        m_rready  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                cmd_full = 1'b0;
            end
            ST_WRITE: begin
                m_awvalid = ~r_aw_done;
                m_wvalid  = ~r_w_done;
            end
            ST_BRESP: begin
                // A held response back-pressures the slave.
                m_bready = r_rsp_empty;
            end
            ST_READ: begin
                m_arvalid = 1'b1;
            end
            ST_RDATA: begin
                m_rready = r_rsp_empty;
            end
            default: begin
                cmd_full = 1'b1;
            end
        endcase
    end

    // Command capture and per-channel completion flags for the write phase.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr    <= {AddrWidth{1'b0}};
            r_wdata   <= {DataWidth{1'b0}};
            r_wstrb   <= {StrbWidth{1'b0}};
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else if (w_cmd_accept) begin
            r_addr    <= cmd_addr;
            r_wdata   <= cmd_wdata;
            r_wstrb   <= cmd_wstrb;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            if (w_aw_hs) begin
                r_aw_done <= 1'b1;
            end
            if (w_w_hs) begin
                r_w_done <= 1'b1;
            end
        end
    end

    // Response holding register. Loads happen only while empty (ready is gated
    // by r_rsp_empty), so a load and a pop are never in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rsp_empty <= 1'b1;
            r_rsp_write <= 1'b0;
            r_rsp_data  <= {DataWidth{1'b0}};
            r_rsp_resp  <= 2'b00;
        end else if (w_b_hs) begin
            r_rsp_empty <= 1'b0;
            r_rsp_write <= 1'b1;
            r_rsp_data  <= {DataWidth{1'b0}};
            r_rsp_resp  <= m_bresp;
        end else if (w_r_hs) begin
            r_rsp_empty <= 1'b0;
            r_rsp_write <= 1'b0;
            r_rsp_data  <= m_rdata;
            r_rsp_resp  <= m_rresp;
        end else if (rsp_pop & ~r_rsp_empty) begin
            r_rsp_empty <= 1'b1;
        end
    end

endmodule

// File: tb/tb_axil_cmd_master.sv
// -----------------------------------------------------------------------------
// Testbench for axil_cmd_master: directed commands, a delay-configurable
// AXI4-Lite slave model, and a scoreboard monitor on the response side.
// -----------------------------------------------------------------------------
module tb_axil_cmd_master;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cmd_push;
    logic          cmd_full;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [3:0]    cmd_wstrb;
    logic          rsp_pop;
    logic          rsp_empty;
    logic          rsp_write;
    logic [DW-1:0] rsp_data;
    logic [1:0]    rsp_resp;
    logic          m_awvalid, m_awready;
    logic [AW-1:0] m_awaddr;
    logic [2:0]    m_awprot;
    logic          m_wvalid, m_wready;
    logic [DW-1:0] m_wdata;
    logic [3:0]    m_wstrb;
    logic          m_bvalid, m_bready;
    logic [1:0]    m_bresp;
    logic          m_arvalid, m_arready;
    logic [AW-1:0] m_araddr;
    logic [2:0]    m_arprot;
    logic          m_rvalid, m_rready;
    logic [DW-1:0] m_rdata;
    logic [1:0]    m_rresp;

    axil_cmd_master #(.AddrWidth(AW), .DataWidth(DW)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_push(cmd_push), .cmd_full(cmd_full), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_pop(rsp_pop), .rsp_empty(rsp_empty), .rsp_write(rsp_write),
        .rsp_data(rsp_data), .rsp_resp(rsp_resp),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awprot(m_awprot),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arprot(m_arprot),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic          wr;
        logic [DW-1:0] data;
        logic [1:0]    resp;
    } exp_t;
    exp_t sb_q[$];
    logic pop_en = 1'b1;

    // Expected AXI payload of the command currently in flight.
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata;
    logic [3:0]    exp_wstrb;

    // Slave configuration and state.
    int         aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic [1:0] cfg_bresp = 2'b00, cfg_rresp = 2'b00;
    logic [DW-1:0] cfg_rdata = 32'h0;
    int   aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    logic aw_got, w_got, ar_got, aw_seen, w_seen, ar_seen, b_fire, r_fire;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic slv_clear();
        m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_arready = 1'b0; m_rvalid = 1'b0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        aw_got = 1'b0; w_got = 1'b0; ar_got = 1'b0;
        aw_seen = 1'b0; w_seen = 1'b0; ar_seen = 1'b0;
        b_fire = 1'b0; r_fire = 1'b0;
    endtask

    // Slave model: decides everything on the falling edge; a ready raised while
    // valid is high completes on the next rising edge.
    initial begin
        slv_clear();
        m_bresp = 2'b00; m_rdata = 32'h0; m_rresp = 2'b00;
        forever begin
            @(negedge clk);
            if (b_fire) begin
                m_bvalid = 1'b0; b_fire = 1'b0;
                aw_got = 1'b0; w_got = 1'b0; aw_seen = 1'b0; w_seen = 1'b0;
            end
            if (r_fire) begin
                m_rvalid = 1'b0; r_fire = 1'b0; ar_got = 1'b0; ar_seen = 1'b0;
            end
            if (m_awready) begin m_awready = 1'b0; aw_got = 1'b1; end
            if (m_wready)  begin m_wready  = 1'b0; w_got  = 1'b1; end
            if (m_arready) begin m_arready = 1'b0; ar_got = 1'b1; end
            // AW
            if (aw_got) begin
                if (m_awvalid) chk("awvalid_after_hs", m_awvalid, 1'b0);
            end else if (m_awvalid) begin
                aw_seen = 1'b1;
                chk("awaddr", m_awaddr, exp_addr);
                chk("awprot", m_awprot, 3'b000);
                if (aw_cnt >= aw_dly) begin m_awready = 1'b1; aw_cnt = 0; end
                else aw_cnt++;
            end else if (aw_seen) begin
                chk("awvalid_stable", m_awvalid, 1'b1);
            end
            // W
            if (w_got) begin
                if (m_wvalid) chk("wvalid_after_hs", m_wvalid, 1'b0);
            end else if (m_wvalid) begin
                w_seen = 1'b1;
                chk("wdata", m_wdata, exp_wdata);
                chk("wstrb", m_wstrb, exp_wstrb);
                if (w_cnt >= w_dly) begin m_wready = 1'b1; w_cnt = 0; end
                else w_cnt++;
            end else if (w_seen) begin
                chk("wvalid_stable", m_wvalid, 1'b1);
            end
            // AR
            if (ar_got) begin
                if (m_arvalid) chk("arvalid_after_hs", m_arvalid, 1'b0);
            end else if (m_arvalid) begin
                ar_seen = 1'b1;
                chk("araddr", m_araddr, exp_addr);
                chk("arprot", m_arprot, 3'b000);
                if (ar_cnt >= ar_dly) begin m_arready = 1'b1; ar_cnt = 0; end
                else ar_cnt++;
            end else if (ar_seen) begin
                chk("arvalid_stable", m_arvalid, 1'b1);
            end
            // B
            if (aw_got && w_got && !m_bvalid) begin
                if (b_cnt >= b_dly) begin m_bvalid = 1'b1; m_bresp = cfg_bresp; b_cnt = 0; end
                else b_cnt++;
            end
            if (m_bvalid) begin
                if (!rsp_empty) chk("bready_backpressure", m_bready, 1'b0);
                if (m_bready) b_fire = 1'b1;
            end
            // R
            if (ar_got && !m_rvalid) begin
                if (r_cnt >= r_dly) begin
                    m_rvalid = 1'b1; m_rdata = cfg_rdata; m_rresp = cfg_rresp; r_cnt = 0;
                end else r_cnt++;
            end
            if (m_rvalid) begin
                if (!rsp_empty) chk("rready_backpressure", m_rready, 1'b0);
                if (m_rready) r_fire = 1'b1;
            end
        end
    end

    // Scoreboard monitor: compares and pops every presented response.
    initial begin
        exp_t e;
        rsp_pop = 1'b0;
        forever begin
            @(negedge clk);
            rsp_pop = 1'b0;
            if (reset_n && !rsp_empty && pop_en) begin
                if (sb_q.size() == 0) begin
                    chk("rsp_unexpected", 1'b1, 1'b0);
                end else begin
                    e = sb_q.pop_front();
                    chk("rsp_write", rsp_write, e.wr);
                    chk("rsp_data", rsp_data, e.data);
                    chk("rsp_resp", rsp_resp, e.resp);
                end
                rsp_pop = 1'b1;
            end
        end
    end

    // Called at a falling edge; returns at the falling edge after the push edge.
    task automatic issue(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input logic [3:0] strb, input logic [1:0] resp, input logic [DW-1:0] rdexp);
        exp_t e;
        int n = 0;
        while (cmd_full && n < 200) begin @(negedge clk); n++; end
        chk("issue_wait_timeout", (n < 200), 1'b1);
        exp_addr = addr; exp_wdata = wdata; exp_wstrb = strb;
        cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_wstrb = strb;
        cmd_push = 1'b1;
        e.wr = wr; e.data = wr ? 32'h0 : rdexp; e.resp = resp;
        sb_q.push_back(e);
        @(negedge clk);
        cmd_push = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb_q.size() != 0 || !rsp_empty || cmd_full) && n < 300) begin
            @(negedge clk); n++;
        end
        chk("drain_timeout", (n < 300), 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset_n = 1'b0; cmd_push = 1'b0; cmd_write = 1'b0;
        cmd_addr = 32'h0; cmd_wdata = 32'h0; cmd_wstrb = 4'h0;
        exp_addr = 32'h0; exp_wdata = 32'h0; exp_wstrb = 4'h0;
        repeat (3) @(negedge clk);
        // Reset state
        chk("rst_cmd_full", cmd_full, 1'b0);
        chk("rst_rsp_empty", rsp_empty, 1'b1);
        chk("rst_valids", {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}, 5'b0);
        chk("rst_rsp_fields", {rsp_write, rsp_data, rsp_resp}, 35'h0);
        chk("rst_addr", m_awaddr, 32'h0);
        reset_n = 1'b1;
        @(negedge clk);

        // Zero-wait write with exact latency
        issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 2'b00, 32'h0);
        chk("lat_c1_awvalid", m_awvalid, 1'b1);
        chk("lat_c1_wvalid", m_wvalid, 1'b1);
        chk("lat_c1_awaddr", m_awaddr, 32'h10);
        @(negedge clk);
        chk("lat_c2_bready", m_bready, 1'b1);
        chk("lat_c2_cmd_full", cmd_full, 1'b1);
        @(negedge clk);
        chk("lat_c3_rsp_empty", rsp_empty, 1'b0);
        chk("lat_c3_cmd_full", cmd_full, 1'b0);
        drain();

        // Read with delayed arready and rvalid
        ar_dly = 3; r_dly = 2; cfg_rdata = 32'h12345678;
        issue(1'b0, 32'h2000_0040, 32'h0, 4'h0, 2'b00, 32'h12345678);
        drain();

        // Split write: W first, AW four cycles later
        ar_dly = 0; r_dly = 0; aw_dly = 4; w_dly = 0;
        issue(1'b1, 32'h104, 32'hCAFE0001, 4'h3, 2'b00, 32'h0);
        @(negedge clk);
        chk("splitA_wvalid", m_wvalid, 1'b0);
        chk("splitA_awvalid", m_awvalid, 1'b1);
        drain();
        // Split write: AW first, W four cycles later
        aw_dly = 0; w_dly = 4;
        issue(1'b1, 32'h208, 32'h0BAD_F00D, 4'hC, 2'b00, 32'h0);
        @(negedge clk);
        chk("splitB_awvalid", m_awvalid, 1'b0);
        chk("splitB_wvalid", m_wvalid, 1'b1);
        drain();

        // Backpressure: hold a write response, then run a read
        w_dly = 0; pop_en = 1'b0;
        issue(1'b1, 32'h200, 32'h11112222, 4'hF, 2'b00, 32'h0);
        n = 0;
        while (rsp_empty && n < 50) begin @(negedge clk); n++; end
        chk("bp_rsp_held", rsp_empty, 1'b0);
        cfg_rdata = 32'hA5A50F0F;
        issue(1'b0, 32'h300, 32'h0, 4'h0, 2'b00, 32'hA5A50F0F);
        chk("bp_cmd_full", cmd_full, 1'b1);
        // This push must be ignored
        cmd_write = 1'b1; cmd_addr = 32'h999; cmd_push = 1'b1;
        @(negedge clk);
        cmd_push = 1'b0;
        repeat (4) @(negedge clk);
        chk("bp_rready_low", m_rready, 1'b0);
        chk("bp_still_full", cmd_full, 1'b1);
        chk("bp_rvalid_waiting", m_rvalid, 1'b1);
        pop_en = 1'b1;
        drain();

        // Error responses pass through
        cfg_bresp = 2'b10;
        issue(1'b1, 32'h44, 32'h55AA55AA, 4'h1, 2'b10, 32'h0);
        drain();
        cfg_bresp = 2'b00; cfg_rresp = 2'b11; cfg_rdata = 32'h0000BEEF;
        issue(1'b0, 32'h48, 32'h0, 4'h0, 2'b11, 32'h0000BEEF);
        drain();
        cfg_rresp = 2'b00;

        // Reset in the middle of a read
        ar_dly = 20;
        issue(1'b0, 32'h400, 32'h0, 4'h0, 2'b00, 32'h0);
        chk("mid_arvalid_before", m_arvalid, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_arvalid", m_arvalid, 1'b0);
        chk("mid_rst_cmd_full", cmd_full, 1'b0);
        chk("mid_rst_rsp_empty", rsp_empty, 1'b1);
        sb_q.delete();
        slv_clear();
        ar_dly = 0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_rst_rsp_empty", rsp_empty, 1'b1);
        issue(1'b1, 32'h500, 32'h0F0F0F0F, 4'hA, 2'b00, 32'h0);
        drain();
        repeat (3) @(negedge clk);
        chk("final_queue_empty", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
